sdram_arbit: RTL and testbench

- Command arbiter between the SDRAM init, auto-refresh, write and read stages and the physical SDRAM pins.
- Downstream of sdram_init, sdram_write and sdram_read, and of the auto-refresh stage.
- Grants the command bus to one requester at a time: refresh first, then write, then read.
- Multiplexes cmd/ba/addr onto the pins, owns the bidirectional DQ tri-state and returns read data to the read stage.

---
 rtl/sdram_arbit_if.sv | 61 ++++++
 rtl/sdram_arbit.sv | 97 +++++++++
 tb/tb_sdram_arbit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_if.sv
// Command-side bundle between the SDRAM stages, the arbiter and the SDRAM pins.
// DQ stays outside the bundle as a plain inout so tri-state resolution lives on a real net.
interface sdram_arbit_if;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end;

  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic        aref_end;

  logic        wr_req;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_data;
  logic        wr_end;

  logic        rd_req;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        rd_end;

  logic        aref_en;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_data;

  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  // Arbiter side.
  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
    input  wr_req, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data, wr_end,
    input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    output aref_en, wr_en, rd_en, rd_data,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );

  // Stage / pin side.
  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
    output wr_req, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data, wr_end,
    output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    input  aref_en, wr_en, rd_en, rd_data,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants the pins to init, refresh, write or read (fixed priority)
// and owns the DQ tri-state.
module sdram_arbit #(
  parameter logic [3:0]  NOP_CMD   = 4'b0111,
  parameter logic [1:0]  IDLE_BA   = 2'b11,
  parameter logic [12:0] IDLE_ADDR = 13'h1FFF
) (
  input  logic         clk_100m,
  input  logic         rst_n,
  sdram_arbit_if.slave bus,
  inout  wire [15:0]   sdram_dq
);

  typedef enum logic [2:0] {StInit, StArbit, StAref, StWrite, StRead} state_e;

  state_e      state_q, state_d;
  logic        aref_en_q, wr_en_q, rd_en_q;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (bus.init_end) state_d = StArbit;
      StArbit: begin
        if (bus.aref_req)    state_d = StAref;
        else if (bus.wr_req) state_d = StWrite;
        else if (bus.rd_req) state_d = StRead;
      end
      StAref:  if (bus.aref_end) state_d = StArbit;
      StWrite: if (bus.wr_end)   state_d = StArbit;
      StRead:  if (bus.rd_end)   state_d = StArbit;
      default: state_d = StInit;
    endcase
  end

  // Grants are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == StAref);
      wr_en_q   <= (state_d == StWrite);
      rd_en_q   <= (state_d == StRead);
    end
  end

  always_comb begin
    cmd  = NOP_CMD;
    ba   = IDLE_BA;
    addr = IDLE_ADDR;
    unique case (state_q)
      StInit: begin
        cmd  = bus.init_cmd;
        ba   = bus.init_ba;
        addr = bus.init_addr;
      end
      StAref: begin
        cmd  = bus.aref_cmd;
        ba   = bus.aref_ba;
        addr = bus.aref_addr;
      end
      StWrite: begin
        cmd  = bus.wr_cmd;
        ba   = bus.wr_ba;
        addr = bus.wr_addr;
      end
      StRead: begin
        cmd  = bus.rd_cmd;
        ba   = bus.rd_ba;
        addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  assign bus.aref_en     = aref_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.sdram_cke   = 1'b1;
  assign bus.sdram_cs_n  = cmd[3];
  assign bus.sdram_ras_n = cmd[2];
  assign bus.sdram_cas_n = cmd[1];
  assign bus.sdram_we_n  = cmd[0];
  assign bus.sdram_ba    = ba;
  assign bus.sdram_addr  = addr;

  // Only a granted write may drive DQ; a stray wr_sdram_en elsewhere is ignored.
  assign sdram_dq    = (state_q == StWrite && bus.wr_sdram_en) ? bus.wr_data : 16'hzzzz;
  assign bus.rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed sequences, a grant-sequence vector table and
// randomized traffic against an owner-based reference model.
module tb_sdram_arbit;

  localparam int OwInit = 0;
  localparam int OwIdle = 1;
  localparam int OwAref = 2;
  localparam int OwWr   = 3;
  localparam int OwRd   = 4;

  logic        clk_100m = 1'b0;
  logic        rst_n    = 1'b1;
  logic        tb_drv_en;
  logic [15:0] tb_drv   = 16'h0000;
  wire  [15:0] sdram_dq;

  int m_owner = OwInit;
  int n_err   = 0;
  int n_chk   = 0;

  sdram_arbit_if bus ();

  sdram_arbit dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .sdram_dq (sdram_dq)
  );

  always #5 clk_100m = ~clk_100m;

  // The bench plays the SDRAM: it drives DQ whenever the arbiter should have released it.
  always_comb tb_drv_en = !(m_owner == OwWr && bus.wr_sdram_en);
  assign sdram_dq = tb_drv_en ? tb_drv : 16'hzzzz;

  typedef struct packed {
    logic [2:0] req;   // {aref, wr, rd}
    logic [2:0] ends;  // {aref, wr, rd}
    logic [2:0] grant; // expected {aref_en, wr_en, rd_en} after the edge
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Owner after one edge: idle hands the bus to the first requester in priority order,
  // a busy owner only lets go on its own end pulse.
  function automatic int next_owner(int o);
    int   order[3] = '{OwAref, OwWr, OwRd};
    logic req[3];
    logic fin[5];
    req = '{bus.aref_req, bus.wr_req, bus.rd_req};
    fin = '{bus.init_end, 1'b0, bus.aref_end, bus.wr_end, bus.rd_end};
    if (o == OwIdle) begin
      for (int i = 0; i < 3; i++) if (req[i]) return order[i];
      return OwIdle;
    end
    return fin[o] ? OwIdle : o;
  endfunction

  task automatic check_all();
    logic [18:0] exp_pins;
    case (m_owner)
      OwInit:  exp_pins = {bus.init_cmd, bus.init_ba, bus.init_addr};
      OwAref:  exp_pins = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
      OwWr:    exp_pins = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
      OwRd:    exp_pins = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
      default: exp_pins = {4'b0111, 2'b11, 13'h1FFF};
    endcase
    chk("aref_en", 32'(bus.aref_en), 32'(m_owner == OwAref));
    chk("wr_en", 32'(bus.wr_en), 32'(m_owner == OwWr));
    chk("rd_en", 32'(bus.rd_en), 32'(m_owner == OwRd));
    chk("cke", 32'(bus.sdram_cke), 32'd1);
    chk("pins", 32'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                     bus.sdram_ba, bus.sdram_addr}), 32'(exp_pins));
    if (m_owner == OwWr && bus.wr_sdram_en) chk("dq_drive", 32'(sdram_dq), 32'(bus.wr_data));
    else                                    chk("dq_release", 32'(bus.rd_data), 32'(tb_drv));
  endtask

  task automatic tick();
    int nxt;
    nxt = next_owner(m_owner);
    @(posedge clk_100m);
    #2;
    if (rst_n) m_owner = nxt;
    #1;
    check_all();
  endtask

  task automatic clear_ctl();
    {bus.aref_req, bus.wr_req, bus.rd_req}    = 3'b000;
    {bus.aref_end, bus.wr_end, bus.rd_end}    = 3'b000;
    bus.wr_sdram_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = {3'b111, 3'b000, 3'b100};  // all three at once: refresh wins
    vecs[1]  = {3'b011, 3'b100, 3'b000};  // refresh done -> one NOP cycle
    vecs[2]  = {3'b011, 3'b000, 3'b010};  // write next
    vecs[3]  = {3'b001, 3'b101, 3'b010};  // foreign end pulses ignored
    vecs[4]  = {3'b001, 3'b010, 3'b000};
    vecs[5]  = {3'b001, 3'b000, 3'b001};  // read last
    vecs[6]  = {3'b100, 3'b110, 3'b001};  // busy: req and foreign ends ignored
    vecs[7]  = {3'b100, 3'b001, 3'b000};
    vecs[8]  = {3'b100, 3'b000, 3'b100};
    vecs[9]  = {3'b000, 3'b100, 3'b000};
    vecs[10] = {3'b000, 3'b000, 3'b000};
    vecs[11] = {3'b000, 3'b111, 3'b000};  // end pulses in ARBIT do nothing

    clear_ctl();
    bus.init_end  = 1'b0;
    bus.init_cmd  = 4'b0001;  bus.init_ba = 2'b01; bus.init_addr = 13'h0400;
    bus.aref_cmd  = 4'b0001;  bus.aref_ba = 2'b00; bus.aref_addr = 13'h0011;
    bus.wr_cmd    = 4'b0100;  bus.wr_ba   = 2'b10; bus.wr_addr   = 13'h0123;
    bus.rd_cmd    = 4'b0101;  bus.rd_ba   = 2'b01; bus.rd_addr   = 13'h0ABC;
    bus.wr_data   = 16'h5A5A;

    // Reset and init.
    #1 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk_100m) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.init_end = 1'b1;
    tick();
    chk("idle_pins", 32'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                          bus.sdram_ba, bus.sdram_addr}), 32'({4'b0111, 2'b11, 13'h1FFF}));

    // Single write with DQ drive.
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    bus.wr_sdram_en = 1'b1;
    bus.wr_data = 16'h00A5;
    #1 chk("dq_a5", 32'(sdram_dq), 32'h00A5);
    tick();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("wr_en_fall", 32'(bus.wr_en), 32'd0);
    tick();  // wr_sdram_en still high in ARBIT: must not reach the bus
    bus.wr_sdram_en = 1'b0;

    // Grant-sequence table.
    for (int i = 0; i < 12; i++) begin
      {bus.aref_req, bus.wr_req, bus.rd_req} = vecs[i].req;
      {bus.aref_end, bus.wr_end, bus.rd_end} = vecs[i].ends;
      tick();
      chk($sformatf("vec%0d_grant", i), 32'({bus.aref_en, bus.wr_en, bus.rd_en}),
          32'(vecs[i].grant));
    end
    clear_ctl();

    // Read returns DQ from the device.
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tb_drv = 16'h1234;
    #1 chk("rd_data_1234", 32'(bus.rd_data), 32'h1234);
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    tb_drv = 16'h0000;

    // Refresh request during a write waits for the write to end.
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    bus.aref_req = 1'b1;
    tick();
    tick();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("aref_wait_arbit", 32'(bus.aref_en), 32'd0);
    tick();
    chk("aref_granted", 32'(bus.aref_en), 32'd1);
    bus.aref_req = 1'b0;
    bus.aref_end = 1'b1;
    tick();
    clear_ctl();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.aref_req    = ($urandom_range(0, 5) == 0);
      bus.wr_req      = ($urandom_range(0, 3) == 0);
      bus.rd_req      = ($urandom_range(0, 3) == 0);
      bus.aref_end    = ($urandom_range(0, 3) == 0);
      bus.wr_end      = ($urandom_range(0, 3) == 0);
      bus.rd_end      = ($urandom_range(0, 3) == 0);
      bus.init_end    = 1'($urandom);
      bus.wr_sdram_en = 1'($urandom);
      bus.wr_data     = 16'($urandom);
      tb_drv          = 16'($urandom);
      bus.init_cmd    = 4'($urandom);  bus.init_ba = 2'($urandom); bus.init_addr = 13'($urandom);
      bus.aref_cmd    = 4'($urandom);  bus.aref_ba = 2'($urandom); bus.aref_addr = 13'($urandom);
      bus.wr_cmd      = 4'($urandom);  bus.wr_ba   = 2'($urandom); bus.wr_addr   = 13'($urandom);
      bus.rd_cmd      = 4'($urandom);  bus.rd_ba   = 2'($urandom); bus.rd_addr   = 13'($urandom);
      tick();
    end
    clear_ctl();
    tb_drv = 16'h0000;
    bus.wr_data = 16'hFFFF;
    bus.init_end = 1'b1;

    // Reach READ cleanly, then reset asynchronously mid-burst.
    for (int i = 0; i < 4; i++) begin
      {bus.aref_end, bus.wr_end, bus.rd_end} = 3'b111;
      tick();
    end
    {bus.aref_end, bus.wr_end, bus.rd_end} = 3'b000;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("pre_reset_rd_en", 32'(bus.rd_en), 32'd1);
    tick();
    #1 rst_n = 1'b0;
    m_owner = OwInit;
    bus.wr_sdram_en = 1'b1;
    #1 check_all();
    chk("reset_rd_en", 32'(bus.rd_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
